// File: rtl/gps_sample_packer.sv
// gps_sample_packer: packs 2-bit I / 2-bit Q samples into bytes and buffers them in a FIFO
module gps_sample_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               MCU_CLK_25_000,
    input  logic               RESET_N,
    input  logic               DATAREADY,
    input  logic               GPS_I1,
    input  logic               GPS_I0,
    input  logic               GPS_Q1,
    input  logic               GPS_Q0,
    input  logic               CLEAR,
    output logic [7:0]         BYTE_OUT,
    output logic               BYTE_VALID,
    input  logic               BYTE_READY,
    output logic               OVERFLOW,
    output logic [LEVEL_W-1:0] LEVEL
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {PH_HIGH, PH_LOW} ph_e;

    ph_e                ph_q, ph_d;
    logic [3:0]         hold_q, hold_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic [3:0] nibble;
    logic       full, pop, push_req, push;

    assign nibble     = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    assign BYTE_VALID = level_q != '0;
    assign full       = level_q == LEVEL_W'(FIFO_DEPTH);
    assign pop        = BYTE_VALID && BYTE_READY;
    assign push_req   = DATAREADY && ph_q == PH_LOW;
    // a full FIFO still takes the byte when the head leaves on the same edge
    assign push       = push_req && (!full || pop);
    assign BYTE_OUT   = BYTE_VALID ? mem_q[rd_q] : 8'h00;
    assign OVERFLOW   = ovf_q;
    assign LEVEL      = level_q;

    // next-state: nibble phase, pointers, occupancy and sticky drop flag; CLEAR wins
    always_comb begin
        ph_d    = ph_q;
        hold_d  = hold_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (CLEAR) begin
            ph_d    = PH_HIGH;
            hold_d  = '0;
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (DATAREADY) begin
                ph_d   = ph_q == PH_HIGH ? PH_LOW : PH_HIGH;
                hold_d = ph_q == PH_HIGH ? nibble : hold_q;
            end
            wr_d    = push ? wr_q + 1'b1 : wr_q;
            rd_d    = pop ? rd_q + 1'b1 : rd_q;
            level_d = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
            ovf_d   = ovf_q | (push_req && full && !pop);
        end
    end

    // control state register
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            ph_q    <= PH_HIGH;
            hold_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            hold_q  <= hold_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // byte storage; contents are only visible through valid slots, so no reset
    always_ff @(posedge MCU_CLK_25_000) begin
        if (!CLEAR && push) mem_q[wr_q] <= {hold_q, nibble};
    end
endmodule

// File: tb/tb_gps_sample_packer.sv
// tb_gps_sample_packer: randomized and directed checks against a queue-based model
module tb_gps_sample_packer;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 0;
    logic          RESET_N = 0;
    logic          DATAREADY = 0;
    logic          GPS_I1 = 0, GPS_I0 = 0, GPS_Q1 = 0, GPS_Q0 = 0;
    logic          CLEAR = 0;
    logic          BYTE_READY = 0;
    logic [7:0]    BYTE_OUT;
    logic          BYTE_VALID;
    logic          OVERFLOW;
    logic [LW-1:0] LEVEL;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_ph;
    logic [3:0] m_hold;
    bit         m_ovf;

    gps_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .MCU_CLK_25_000(clk), .RESET_N(RESET_N), .DATAREADY(DATAREADY),
        .GPS_I1(GPS_I1), .GPS_I0(GPS_I0), .GPS_Q1(GPS_Q1), .GPS_Q0(GPS_Q0),
        .CLEAR(CLEAR), .BYTE_OUT(BYTE_OUT), .BYTE_VALID(BYTE_VALID),
        .BYTE_READY(BYTE_READY), .OVERFLOW(OVERFLOW), .LEVEL(LEVEL)
    );

    always #20 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        m_ph   = 0;
        m_hold = 0;
        m_ovf  = 0;
    endfunction

    function automatic void model_step(input logic dr, input logic [3:0] nib, input logic rdy, input logic clr);
        if (clr) begin
            model_reset();
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (dr) begin
                if (!m_ph) begin
                    m_hold = nib;
                    m_ph   = 1;
                end else begin
                    m_ph = 0;
                    if (mq.size() < DEPTH) mq.push_back({m_hold, nib});
                    else m_ovf = 1;
                end
            end
        end
    endfunction

    function automatic logic [7:0] m_out();
        return mq.size() > 0 ? mq[0] : 8'h00;
    endfunction

    task automatic tick(input logic dr, input logic [3:0] nib, input logic rdy, input logic clr);
        DATAREADY  = dr;
        {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = nib;
        BYTE_READY = rdy;
        CLEAR      = clr;
        @(posedge clk);
        model_step(dr, nib, rdy, clr);
        #1;
        DATAREADY  = 0;
        BYTE_READY = 0;
        CLEAR      = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rdy);
        tick(1, b[7:4], rdy, 0);
        tick(1, b[3:0], rdy, 0);
    endtask

    task automatic test_reset();
        RESET_N = 0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (BYTE_VALID !== 1'b0 || BYTE_OUT !== 8'h00 || LEVEL !== 4'd0 || OVERFLOW !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: valid=%b out=%h level=%0d ovf=%b want 0/00/0/0", BYTE_VALID, BYTE_OUT, LEVEL, OVERFLOW);
            end
        end
        RESET_N = 1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 4'h0, $urandom_range(0, 1), 0);
            total++;
            if (BYTE_VALID !== 1'b0 || BYTE_OUT !== 8'h00 || LEVEL !== 4'd0 || OVERFLOW !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: valid=%b out=%h level=%0d ovf=%b want 0/00/0/0", BYTE_VALID, BYTE_OUT, LEVEL, OVERFLOW);
            end
        end
    endtask

    task automatic test_packing();
        tick(1, 4'hA, 0, 0);
        total++;
        if (BYTE_VALID !== 1'b0) begin
            bad++;
            $display("FAIL pack_high_only: valid=%b want 0", BYTE_VALID);
        end
        tick(1, 4'h5, 0, 0);
        total++;
        if (BYTE_VALID !== 1'b1 || BYTE_OUT !== 8'hA5 || LEVEL !== 4'd1) begin
            bad++;
            $display("FAIL pack_byte: valid=%b out=%h level=%0d want 1/a5/1", BYTE_VALID, BYTE_OUT, LEVEL);
        end
        tick(0, 4'h0, 0, 0);
        total++;
        if (BYTE_OUT !== 8'hA5 || BYTE_VALID !== 1'b1) begin
            bad++;
            $display("FAIL pack_hold_stable: out=%h valid=%b want a5/1", BYTE_OUT, BYTE_VALID);
        end
        tick(0, 4'h0, 1, 0);
        total++;
        if (BYTE_VALID !== 1'b0 || BYTE_OUT !== 8'h00 || LEVEL !== 4'd0) begin
            bad++;
            $display("FAIL pack_pop: valid=%b out=%h level=%0d want 0/00/0", BYTE_VALID, BYTE_OUT, LEVEL);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push_byte(8'(i), 0);
        total++;
        if (LEVEL !== 4'd8 || OVERFLOW !== 1'b0) begin
            bad++;
            $display("FAIL fill_level: level=%0d ovf=%b want 8/0", LEVEL, OVERFLOW);
        end
        push_byte(8'hFF, 0);
        total++;
        if (LEVEL !== 4'd8 || OVERFLOW !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set: level=%0d ovf=%b want 8/1", LEVEL, OVERFLOW);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (BYTE_VALID !== 1'b1 || BYTE_OUT !== 8'(i)) begin
                bad++;
                $display("FAIL overflow_drain[%0d]: valid=%b out=%h want 1/%h", i, BYTE_VALID, BYTE_OUT, 8'(i));
            end
            tick(0, 4'h0, 1, 0);
        end
        total++;
        if (BYTE_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            bad++;
            $display("FAIL overflow_empty: valid=%b ovf=%b want 0/1", BYTE_VALID, OVERFLOW);
        end
    endtask

    task automatic test_full_push_pop();
        tick(0, 4'h0, 0, 1);
        for (int i = 0; i < 8; i++) push_byte(8'(i), 0);
        tick(1, 4'hC, 0, 0);
        tick(1, 4'h3, 1, 0);
        total++;
        if (OVERFLOW !== 1'b0 || LEVEL !== 4'd8 || BYTE_OUT !== 8'h01) begin
            bad++;
            $display("FAIL full_push_pop: ovf=%b level=%0d out=%h want 0/8/01", OVERFLOW, LEVEL, BYTE_OUT);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want;
            want = i < 7 ? 8'(i + 1) : 8'hC3;
            total++;
            if (BYTE_VALID !== 1'b1 || BYTE_OUT !== want) begin
                bad++;
                $display("FAIL full_drain[%0d]: valid=%b out=%h want 1/%h", i, BYTE_VALID, BYTE_OUT, want);
            end
            tick(0, 4'h0, 1, 0);
        end
        total++;
        if (BYTE_VALID !== 1'b0 || LEVEL !== 4'd0) begin
            bad++;
            $display("FAIL full_drain_end: valid=%b level=%0d want 0/0", BYTE_VALID, LEVEL);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] nib;
        logic       rdy;
        int         strobes;
        int         pops;
        int         errs;
        nib     = 0;
        strobes = 0;
        pops    = 0;
        errs    = 0;
        for (int c = 0; strobes < 2000; c++) begin
            logic dr;
            dr  = c % 3 == 0;
            rdy = $urandom_range(0, 3) != 0;
            if (BYTE_VALID && rdy) pops++;
            tick(dr, nib, rdy, 0);
            if (dr) begin
                nib++;
                strobes++;
            end
            total++;
            if (BYTE_VALID !== (mq.size() > 0) || BYTE_OUT !== m_out() || LEVEL !== LW'(mq.size()) || OVERFLOW !== m_ovf) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL wrap_cycle %0d: valid=%b out=%h level=%0d ovf=%b want %b/%h/%0d/%b",
                             c, BYTE_VALID, BYTE_OUT, LEVEL, OVERFLOW, mq.size() > 0, m_out(), mq.size(), m_ovf);
            end
        end
        for (int i = 0; i < 20 && BYTE_VALID; i++) begin
            pops++;
            tick(0, 4'h0, 1, 0);
        end
        total++;
        if (pops !== 1000 || OVERFLOW !== 1'b0) begin
            bad++;
            $display("FAIL wrap_count: popped=%0d ovf=%b want 1000/0", pops, OVERFLOW);
        end
    endtask

    task automatic setup_mid_state();
        tick(0, 4'h0, 0, 1);
        for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i), 0);
        for (int i = 0; i < 5; i++) tick(0, 4'h0, 1, 0);
        tick(1, 4'h3, 0, 0);
        total++;
        if (LEVEL !== 4'd3 || OVERFLOW !== 1'b1 || BYTE_OUT !== 8'h15) begin
            bad++;
            $display("FAIL mid_setup: level=%0d ovf=%b out=%h want 3/1/15", LEVEL, OVERFLOW, BYTE_OUT);
        end
    endtask

    task automatic test_clear();
        setup_mid_state();
        tick(1, 4'hF, 0, 1);
        total++;
        if (LEVEL !== 4'd0 || OVERFLOW !== 1'b0 || BYTE_VALID !== 1'b0 || BYTE_OUT !== 8'h00) begin
            bad++;
            $display("FAIL clear_state: level=%0d ovf=%b valid=%b out=%h want 0/0/0/00", LEVEL, OVERFLOW, BYTE_VALID, BYTE_OUT);
        end
        tick(1, 4'h6, 0, 0);
        tick(1, 4'h9, 0, 0);
        total++;
        if (BYTE_OUT !== 8'h69 || LEVEL !== 4'd1 || BYTE_OUT !== m_out()) begin
            bad++;
            $display("FAIL clear_realign: out=%h level=%0d want 69/1", BYTE_OUT, LEVEL);
        end
    endtask

    task automatic test_reset_mid();
        setup_mid_state();
        RESET_N = 0;
        model_reset();
        #1;
        total++;
        if (LEVEL !== 4'd0 || OVERFLOW !== 1'b0 || BYTE_VALID !== 1'b0 || BYTE_OUT !== 8'h00) begin
            bad++;
            $display("FAIL reset_async: level=%0d ovf=%b valid=%b out=%h want 0/0/0/00", LEVEL, OVERFLOW, BYTE_VALID, BYTE_OUT);
        end
        @(posedge clk);
        #1;
        RESET_N = 1;
        tick(1, 4'h6, 0, 0);
        tick(1, 4'h9, 0, 0);
        total++;
        if (BYTE_OUT !== 8'h69 || LEVEL !== 4'd1 || BYTE_OUT !== m_out()) begin
            bad++;
            $display("FAIL reset_realign: out=%h level=%0d want 69/1", BYTE_OUT, LEVEL);
        end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gps_sample_packer.md
# gps_sample_packer

Packs the synchronized 2-bit I / 2-bit Q GPS samples into bytes and buffers them in a small FIFO for the SPI output stage. Sits between the four sample synchronizers plus the 4.092 MHz edge detector (upstream) and the SPI serializer (downstream), all in the MCU_CLK_25_000 domain. Absorbs SPI framing gaps so no sample is lost while the serializer is busy.

## Interface

Parameters:
- FIFO_DEPTH, 8: byte entries; power of two, ≥ 2.
- LEVEL_W, $clog2(FIFO_DEPTH)+1: width of LEVEL.

Ports:
- MCU_CLK_25_000  input  1  sole clock; all state on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- DATAREADY  input  1  single-cycle strobe, one per 4.092 MHz GPS sample period.
- GPS_I1, GPS_I0, GPS_Q1, GPS_Q0  input  1 each  synchronized sample bits.
- CLEAR  input  1  synchronous flush.
- BYTE_OUT  output  8  FIFO head byte.
- BYTE_VALID  output  1  FIFO non-empty.
- BYTE_READY  input  1  consumer accepts head this cycle.
- OVERFLOW  output  1  sticky: a packed byte was dropped.
- LEVEL  output  LEVEL_W  bytes currently stored, 0..FIFO_DEPTH.

## Operation

- Sample nibble = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0}.
- Phase register PH (1 bit), two states:
  - PH=0 (HIGH): on DATAREADY, nibble → hold[7:4], PH→1.
  - PH=1 (LOW): on DATAREADY, byte {hold[7:4], nibble} is pushed, PH→0.
- DATAREADY with PH=0 never pushes.
- FIFO: circular buffer, write/read pointers wrap modulo FIFO_DEPTH; LEVEL tracks occupancy.
- Pop occurs when BYTE_VALID && BYTE_READY. BYTE_READY while empty is ignored.
- Push is accepted when LEVEL < FIFO_DEPTH, or when LEVEL == FIFO_DEPTH and a pop occurs in the same cycle. In that case LEVEL stays FIFO_DEPTH and the new byte lands in the freed slot.
- Push while full with no pop:
  - The byte is dropped and OVERFLOW is set.
  - FIFO contents and pointers are unchanged.
  - PH still returns to 0, so nibble alignment is preserved.
- Simultaneous push and pop with 0 < LEVEL < FIFO_DEPTH: LEVEL unchanged.
- Push while empty: LEVEL becomes 1 and BYTE_VALID rises the next cycle.
- BYTE_OUT:
  - When BYTE_VALID=1, it is the oldest stored byte.
  - When BYTE_VALID=0, it is forced to 8'h00.
  - It is held stable while BYTE_VALID && !BYTE_READY.
- CLEAR (synchronous, highest priority over push/pop):
  - Pointers and LEVEL → 0, PH → 0, hold → 0, OVERFLOW → 0.
  - A DATAREADY in the CLEAR cycle is discarded.
- OVERFLOW clears only on RESET_N low or CLEAR.

## Timing

- Reset values (async, immediate): BYTE_OUT=8'h00, BYTE_VALID=0, OVERFLOW=0, LEVEL=0, PH=0, hold=0, pointers=0.
- Reset deassertion mid-stream: the first DATAREADY after release is a HIGH nibble.
- Sampling: GPS_* bits are captured on the same edge where DATAREADY=1. There is no extra input pipeline.
- Push latency: the LOW-nibble DATAREADY edge writes the byte.
  - LEVEL and BYTE_VALID update on that same edge, visible the following cycle.
  - BYTE_OUT shows the byte that same following cycle if the FIFO was empty.
- Pop: on an edge with BYTE_VALID && BYTE_READY, the next head appears the following cycle, or BYTE_VALID drops if LEVEL was 1.
- Throughput: a DATAREADY period of ~6.11 cycles gives one byte per ~12.2 cycles. Sustained consumer rate must be ≥ 1 byte / 12 cycles.
- OVERFLOW rises the cycle after the dropping edge.

## Test plan

- Reset/idle: hold RESET_N low for 5 cycles, then release with no DATAREADY → BYTE_VALID=0, BYTE_OUT=8'h00, LEVEL=0, OVERFLOW=0 throughout.
- Packing: strobes with nibbles 4'hA then 4'h5, BYTE_READY=0 → one cycle after the second strobe, BYTE_VALID=1, BYTE_OUT=8'hA5, LEVEL=1. Assert BYTE_READY for one cycle → BYTE_VALID=0 the next cycle.
- Fill/overflow (DEPTH 8): push bytes 8'h00..8'h07, BYTE_READY=0 → LEVEL=8. Push a ninth byte 8'hFF → OVERFLOW=1, LEVEL=8. Drain → 00..07 in order, 8'hFF is never output.
- Full with simultaneous push/pop: LEVEL=8, BYTE_READY=1 on the push edge of 8'hC3 → no OVERFLOW, LEVEL=8. Drain yields 01..07 then C3.
- Wrap-around: continuous 8 MHz-equivalent strobes with random BYTE_READY (≥50% duty), 1000 bytes, incrementing-nibble pattern → output sequence matches the scoreboard and pointers wrap more than 100 times.
- CLEAR/reset mid-operation: after a HIGH nibble 4'h3 and LEVEL=3 with OVERFLOW set, pulse CLEAR → LEVEL=0, OVERFLOW=0. Nibbles 4'h6, 4'h9 then yield 8'h69. Repeat using RESET_N instead of CLEAR → same result.
